// File: rtl/mc5_pwm_commutator.sv
// Six-step BLDC commutator: hall-decoded leg roles, PWM on the source leg, per-leg dead time,
// RUN/FAULT supervision with watchdog. Define MC5_BRAKE_EN to brake on the low sides at zero duty.
module mc5_pwm_commutator #(
  parameter int PWM_PERIOD = 1000,
  parameter int DEAD_TIME  = 20,
  parameter int TIMEOUT    = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pwm_data,
  input  logic        pwm_valid,
  output logic        pwm_ready,
  input  logic        fault_in,
  input  logic        fault_clear,
  input  logic [2:0]  hall_uvw,
  input  logic        driver_otw_n,
  input  logic        driver_fault_n,
  output logic        status_driver_otw_n,
  output logic        status_driver_fault_n,
  output logic        status_hall_fault_n,
  output logic [2:0]  gate_h,
  output logic [2:0]  gate_l
);
  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int DW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] DT_LOAD  = DW'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);
  localparam logic signed [16:0] DPOS = 17'(PWM_PERIOD - 1);
  localparam logic signed [16:0] DNEG = -DPOS;

  typedef enum logic {ST_RUN, ST_FAULT} state_t;
  typedef enum logic [1:0] {LEG_OFF, LEG_SRC, LEG_SNK} leg_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic signed [15:0] duty_q, pend_duty_q;
  logic               pend_q;
  logic [WW-1:0]      wd_q;
  logic [2:0]         hall_s1_q, hall_s2_q;
  logic               otw_s1_q, otw_s2_q, flt_s1_q, flt_s2_q;
  leg_t               role_q [3];
  leg_t               role_d [3];
  logic [DW-1:0]      dt_q [3];
  logic [2:0]         gh_q, gl_q, gh_d, gl_d;
  logic               hall_bad, wd_expired, fault_src, accept, wrap;
  logic signed [16:0] din;
  logic signed [15:0] sat_duty;
  logic [15:0]        mag, cnt16;
  logic [1:0]         pos_leg, neg_leg, src_leg, snk_leg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hall_s1_q <= 3'b001;
      hall_s2_q <= 3'b001;
      otw_s1_q  <= 1'b1;
      otw_s2_q  <= 1'b1;
      flt_s1_q  <= 1'b1;
      flt_s2_q  <= 1'b1;
    end else begin
      hall_s1_q <= hall_uvw;
      hall_s2_q <= hall_s1_q;
      otw_s1_q  <= driver_otw_n;
      otw_s2_q  <= otw_s1_q;
      flt_s1_q  <= driver_fault_n;
      flt_s2_q  <= flt_s1_q;
    end
  end

  assign status_hall_fault_n   = !hall_bad;
  assign status_driver_otw_n   = otw_s2_q;
  assign status_driver_fault_n = flt_s2_q;
  assign hall_bad   = (hall_s2_q == 3'b000) || (hall_s2_q == 3'b111);
  assign wd_expired = (wd_q == WD_LIMIT);
  assign fault_src  = fault_in || !flt_s2_q || hall_bad || wd_expired;
  assign pwm_ready  = (state_q == ST_RUN) && !pend_q;
  assign accept     = pwm_valid && pwm_ready;
  assign wrap       = (cnt_q == '0);
  assign mag        = duty_q[15] ? $unsigned(-duty_q) : $unsigned(duty_q);
  assign cnt16      = 16'(cnt_q);
  assign gate_h     = gh_q;
  assign gate_l     = gl_q;

  // Saturate on acceptance so the active duty is always within +/-(PWM_PERIOD-1).
  always_comb begin
    din = $signed({pwm_data[15], pwm_data});
    if (din > DPOS)      sat_duty = DPOS[15:0];
    else if (din < DNEG) sat_duty = DNEG[15:0];
    else                 sat_duty = din[15:0];
  end

  // Leg index 2=U, 1=V, 0=W; index 3 means no leg (invalid hall code).
  always_comb begin
    pos_leg = 2'd3;
    neg_leg = 2'd3;
    case (hall_s2_q)
      3'b101:  begin pos_leg = 2'd2; neg_leg = 2'd1; end
      3'b100:  begin pos_leg = 2'd2; neg_leg = 2'd0; end
      3'b110:  begin pos_leg = 2'd1; neg_leg = 2'd0; end
      3'b010:  begin pos_leg = 2'd1; neg_leg = 2'd2; end
      3'b011:  begin pos_leg = 2'd0; neg_leg = 2'd2; end
      3'b001:  begin pos_leg = 2'd0; neg_leg = 2'd1; end
      default: ;
    endcase
    src_leg = duty_q[15] ? neg_leg : pos_leg;
    snk_leg = duty_q[15] ? pos_leg : neg_leg;
    for (int unsigned i = 0; i < 3; i++) begin
      role_d[i] = LEG_OFF;
      if (state_q == ST_RUN) begin
        if (mag != '0) begin
          if (2'(i) == src_leg)      role_d[i] = LEG_SRC;
          else if (2'(i) == snk_leg) role_d[i] = LEG_SNK;
        end
`ifdef MC5_BRAKE_EN
        if (mag == '0) role_d[i] = LEG_SNK;
`endif
      end
    end
  end

  // A role change blanks the leg on the detecting cycle plus DEAD_TIME-1 countdown cycles.
  always_comb begin
    gh_d = '0;
    gl_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (state_q == ST_RUN && !fault_src && role_d[i] == role_q[i] && dt_q[i] == '0) begin
        gh_d[i] = (role_q[i] == LEG_SRC) && (cnt16 < mag);
        gl_d[i] = (role_q[i] == LEG_SNK);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        role_q[i] <= LEG_OFF;
        dt_q[i]   <= '0;
      end
      gh_q <= '0;
      gl_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (role_d[i] != role_q[i]) begin
          role_q[i] <= role_d[i];
          dt_q[i]   <= DT_LOAD;
        end else if (dt_q[i] != '0) begin
          dt_q[i] <= dt_q[i] - 1'b1;
        end
      end
      gh_q <= gh_d;
      gl_q <= gl_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FAULT;
      cnt_q       <= '0;
      duty_q      <= '0;
      pend_duty_q <= '0;
      pend_q      <= 1'b0;
      wd_q        <= '0;
    end else begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      case (state_q)
        ST_RUN: begin
          if (fault_src) begin
            state_q <= ST_FAULT;
            duty_q  <= '0;
            pend_q  <= 1'b0;
            wd_q    <= '0;
          end else begin
            if (accept) begin
              pend_q      <= 1'b1;
              pend_duty_q <= sat_duty;
              wd_q        <= '0;
            end else if (!wd_expired) begin
              wd_q <= wd_q + 1'b1;
            end
            if (wrap && pend_q) begin
              duty_q <= pend_duty_q;
              pend_q <= 1'b0;
            end
          end
        end
        default: begin
          duty_q <= '0;
          pend_q <= 1'b0;
          wd_q   <= '0;
          if (fault_clear && !fault_src) state_q <= ST_RUN;
        end
      endcase
    end
  end
endmodule
